request_dispatcher: RTL

REQUEST_DISPATCHER -- requirements
Module: request_dispatcher

---
 rtl/request_dispatcher.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/request_dispatcher.sv
// rtl/request_dispatcher.sv - pending-slot FIFO feeding a fetch/capture/present dispatch FSM
// Optional handshake counter: define REQUEST_DISPATCHER_STATS_EN.
module request_dispatcher #(
    parameter int DATA_WIDTH = 8,
    parameter int LSIZE      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  slot_valid_in,
    input  logic [LSIZE-1:0]      slot_id_in,
    output logic [LSIZE-1:0]      pop_slot_id_out,
    output logic                  pop_en_out,
    input  logic [DATA_WIDTH-1:0] pop_data_in,
    output logic                  req_valid_out,
    output logic [DATA_WIDTH-1:0] req_data_out,
    output logic [LSIZE-1:0]      req_slot_id_out,
    input  logic                  req_ready_in,
    output logic [LSIZE:0]        pending_cnt_out,
    output logic [31:0]           dispatched_cnt_out,
    output logic                  error
);

    localparam int DEPTH = 1 << LSIZE;
    localparam logic [LSIZE:0] FULL_CNT = (LSIZE+1)'(DEPTH);

    typedef enum logic [1:0] {
        DispIdle,
        DispFetch,
        DispCapture,
        DispPresent
    } state_t;

    state_t           state;
    logic [LSIZE-1:0] mem [DEPTH];
    logic [LSIZE-1:0] wr_ptr;
    logic [LSIZE-1:0] rd_ptr;
    logic [LSIZE:0]   count;
    logic             fifo_empty;
    logic             fifo_full;
    logic             handshake;
    logic             pop;
    logic             push;
    logic [LSIZE-1:0] head;

    assign fifo_empty      = (count == '0);
    assign fifo_full       = (count == FULL_CNT);
    assign handshake       = req_valid_out && req_ready_in;
    assign pop             = !fifo_empty && ((state == DispIdle) || (state == DispPresent && handshake));
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push            = slot_valid_in && (!fifo_full || pop);
    assign head            = mem[rd_ptr];
    assign pending_cnt_out = count;

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr] <= slot_id_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            error  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + LSIZE'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + LSIZE'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (LSIZE+1)'(1);
                2'b01:   count <= count - (LSIZE+1)'(1);
                default: count <= count;
            endcase
            if (slot_valid_in && !push) begin
                error <= 1'b1;
            end
        end
    end

    // pop_slot_id_out doubles as the slot register; it drives the store address through fetch and capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= DispIdle;
            pop_slot_id_out <= '0;
            pop_en_out      <= 1'b0;
            req_valid_out   <= 1'b0;
            req_data_out    <= '0;
            req_slot_id_out <= '0;
        end else begin
            case (state)
                DispIdle: begin
                    if (pop) begin
                        pop_slot_id_out <= head;
                        state           <= DispFetch;
                    end
                end
                DispFetch: begin
                    pop_en_out <= 1'b1;
                    state      <= DispCapture;
                end
                DispCapture: begin
                    pop_en_out      <= 1'b0;
                    req_data_out    <= pop_data_in;
                    req_slot_id_out <= pop_slot_id_out;
                    req_valid_out   <= 1'b1;
                    state           <= DispPresent;
                end
                DispPresent: begin
                    if (handshake) begin
                        req_valid_out <= 1'b0;
                        if (pop) begin
                            pop_slot_id_out <= head;
                            state           <= DispFetch;
                        end else begin
                            state <= DispIdle;
                        end
                    end
                end
                default: state <= DispIdle;
            endcase
        end
    end

`ifdef REQUEST_DISPATCHER_STATS_EN
    logic [31:0] dispatched_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            dispatched_cnt <= '0;
        end else if (handshake) begin
            dispatched_cnt <= dispatched_cnt + 32'd1;
        end
    end

    assign dispatched_cnt_out = dispatched_cnt;
`else
    assign dispatched_cnt_out = 32'd0;
`endif

endmodule
